// File: rtl/uart_pkg.sv
// Shared types and default constants for the DE10 UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS_DEFAULT    = 8;

endpackage

// File: rtl/uart_rx_timer.sv
// Bit-period timer: free-running wrap counter that flags the half-bit and
// full-bit points; held at zero while clr is high.
module uart_rx_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clr || (count_q == FULL_M1)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign half_tick = (count_q == HALF_M1);
  assign full_tick = (count_q == FULL_M1);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, frames start/data/stop bits and
// presents each byte on a valid/ready port with overrun and framing status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned   IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 prev_rx_s_q, prev_rx_s_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic                 rx_s;
  logic                 tmr_clr;
  logic                 half_tick, full_tick;
  logic [DATA_BITS:0]   shift_in;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign shift_in = {rx_s, shift_q};

  uart_rx_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (tmr_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
    prev_rx_s_d = rx_s;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    tmr_clr     = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s && prev_rx_s_q) begin
          state_d = START;
          tmr_clr = 1'b1;
        end
      end
      START: begin
        if (half_tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            tmr_clr   = 1'b1;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d   = shift_in[DATA_BITS:1];
          bit_idx_d = bit_idx_q + IW'(1);
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (full_tick) begin
          state_d = IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_q || rx_ready) begin
            // A load coinciding with a handshake leaves overrun as it was.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = overrun_q;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      prev_rx_s_q <= 1'b1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_rx_s_q <= prev_rx_s_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
